// File: rtl/rng_state_reader.sv
// Read-side engine for RNG state byte arrays. It fetches up to MAX_BYTES
// consecutive bytes, one per cycle, from a synchronous byte store. The
// start offset wraps modulo NUM_BYTES. The bytes are packed little-endian
// into one word, which is returned on a valid/ready response channel.
module rng_state_reader #(
    parameter int NUM_BYTES = 32,
    parameter int MAX_BYTES = 4,
    localparam int ADDR_W   = $clog2(NUM_BYTES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W-1:0]            req_offset,
    input  logic [$clog2(MAX_BYTES):0]   req_count,
    output logic                         rd_en,
    output logic [ADDR_W-1:0]            rd_addr,
    input  logic [7:0]                   rd_data,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [8*MAX_BYTES-1:0]       resp_data
);

    localparam int CNT_W = $clog2(MAX_BYTES) + 1;
    localparam logic [ADDR_W:0]  NB_EXT  = (ADDR_W+1)'(NUM_BYTES);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;        // clamped byte count N of the active request
    logic [CNT_W-1:0]  issue_cnt_q;  // reads issued so far
    logic [CNT_W-1:0]  lane_q;       // next byte lane to be captured
    logic [ADDR_W-1:0] addr_q;       // address presented to the store
    logic              cap_en_q;     // rd_data holds a valid byte this cycle
    logic [7:0]        acc_q [MAX_BYTES];

    logic              accept;
    logic [CNT_W-1:0]  n_in;
    logic [ADDR_W-1:0] base_in;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W:0]   off_ext;
    logic [ADDR_W:0]   inc_ext;

    // Clamp the count and reduce the offset and next address modulo NUM_BYTES.
    // Both values are below 2*NUM_BYTES, so one compare-and-subtract is enough,
    // including for a non-power-of-two store.
    always_comb begin
        n_in     = (req_count > MAX_CNT) ? MAX_CNT : req_count;
        off_ext  = {1'b0, req_offset};
        base_in  = (off_ext >= NB_EXT) ? ADDR_W'(off_ext - NB_EXT) : req_offset;
        inc_ext  = {1'b0, addr_q} + (ADDR_W+1)'(1);
        addr_inc = (inc_ext >= NB_EXT) ? ADDR_W'(inc_ext - NB_EXT) : ADDR_W'(inc_ext);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake/strobe outputs.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        rd_en      = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = (n_in == '0) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                rd_en = 1'b1;
                if (issue_cnt_q == cnt_q - CNT_W'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, read-address sequencing and capture-lane tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            issue_cnt_q <= '0;
            lane_q      <= '0;
            addr_q      <= '0;
            cap_en_q    <= 1'b0;
        end else begin
            cap_en_q <= rd_en;
            if (accept) begin
                cnt_q       <= n_in;
                issue_cnt_q <= '0;
                lane_q      <= '0;
                addr_q      <= base_in;
            end else begin
                if (rd_en) begin
                    issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                    addr_q      <= addr_inc;
                end
                if (cap_en_q) begin
                    lane_q <= lane_q + CNT_W'(1);
                end
            end
        end
    end

    assign rd_addr = addr_q;

    // One accumulator byte per lane. Each lane is cleared on acceptance and
    // loaded when its byte returns from the store.
    for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_lane
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q[gi] <= 8'h00;
            end else if (accept) begin
                acc_q[gi] <= 8'h00;
            end else if (cap_en_q && (lane_q == CNT_W'(gi))) begin
                acc_q[gi] <= rd_data;
            end
        end
        assign resp_data[8*gi +: 8] = acc_q[gi];
    end

endmodule

// File: tb/tb_rng_state_reader.sv
// Directed bench for rng_state_reader. It drives two builds: a 32-byte store
// (unit 0) and a 6-byte store (unit 1). Each build has a behavioural
// synchronous byte store.
module tb_rng_state_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus per unit
    logic       req_valid_a  [2];
    logic [4:0] req_offset_a [2];
    logic [2:0] req_count_a  [2];
    logic       resp_ready_a [2];

    // Unit 0 nets (NUM_BYTES=32)
    logic        rdy0, rden0, rv0;
    logic [4:0]  rdaddr0;
    logic [7:0]  rddata0;
    logic [31:0] rdata0;
    // Unit 1 nets (NUM_BYTES=6)
    logic        rdy1, rden1, rv1;
    logic [2:0]  rdaddr1;
    logic [2:0]  off1;
    logic [7:0]  rddata1;
    logic [31:0] rdata1;

    assign off1 = req_offset_a[1][2:0];

    rng_state_reader #(.NUM_BYTES(32), .MAX_BYTES(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a[0]), .req_ready(rdy0),
        .req_offset(req_offset_a[0]), .req_count(req_count_a[0]),
        .rd_en(rden0), .rd_addr(rdaddr0), .rd_data(rddata0),
        .resp_valid(rv0), .resp_ready(resp_ready_a[0]), .resp_data(rdata0)
    );

    rng_state_reader #(.NUM_BYTES(6), .MAX_BYTES(4)) u_dut6 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a[1]), .req_ready(rdy1),
        .req_offset(off1), .req_count(req_count_a[1]),
        .rd_en(rden1), .rd_addr(rdaddr1), .rd_data(rddata1),
        .resp_valid(rv1), .resp_ready(resp_ready_a[1]), .resp_data(rdata1)
    );

    // Behavioural stores: data appears the cycle after rd_en
    logic [7:0] mem0 [32];
    logic [7:0] mem1 [6];
    always @(posedge clk) begin
        if (rden0) rddata0 <= mem0[rdaddr0];
        if (rden1) rddata1 <= mem1[rdaddr1];
    end

    // Read-address logs, sampled on the falling edge
    int log0[$];
    int log1[$];
    always @(negedge clk) begin
        if (rden0) log0.push_back(int'(rdaddr0));
        if (rden1) log1.push_back(int'(rdaddr1));
    end

    // Per-unit output views
    logic        ready_s [2];
    logic        rv_s    [2];
    logic        rden_s  [2];
    logic [31:0] data_s  [2];
    always_comb begin
        ready_s[0] = rdy0;   ready_s[1] = rdy1;
        rv_s[0]    = rv0;    rv_s[1]    = rv1;
        rden_s[0]  = rden0;  rden_s[1]  = rden1;
        data_s[0]  = rdata0; data_s[1]  = rdata1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One full request/response transaction with latency, data and address checks
    task automatic do_req(input int u, input logic [4:0] off, input logic [2:0] cnt,
                          input logic [31:0] exp_data, input int exp_lat);
        int lat;
        int nb;
        int n;
        int q[$];
        logic [31:0] got;
        nb = (u == 0) ? 32 : 6;
        n  = (cnt > 3'd4) ? 4 : int'(cnt);
        if (u == 0) log0.delete(); else log1.delete();
        @(negedge clk);
        req_valid_a[u]  = 1'b1;
        req_offset_a[u] = off;
        req_count_a[u]  = cnt;
        chk("req_ready_idle", {31'b0, ready_s[u]}, 32'd1);
        @(posedge clk);
        #1;
        req_valid_a[u]  = 1'b0;
        req_offset_a[u] = ~off;          // must not affect the latched request
        req_count_a[u]  = cnt ^ 3'b101;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rv_s[u] && lat < 40);
        got = data_s[u];
        chk("latency", lat, exp_lat);
        chk("resp_data", got, exp_data);
        if (u == 0) q = log0; else q = log1;
        chk("num_reads", q.size(), n);
        for (int k = 0; k < n && k < q.size(); k++) begin
            chk("rd_addr", q[k], (int'(off) % nb + k) % nb);
        end
        resp_ready_a[u] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready_a[u] = 1'b0;
        @(negedge clk);
        chk("resp_valid_drop", {31'b0, rv_s[u]}, 32'd0);
        chk("req_ready_back", {31'b0, ready_s[u]}, 32'd1);
        $display("txn unit=%0d off=%0d cnt=%0d data=%h lat=%0d reads=%0d",
                 u, off, cnt, got, lat, q.size());
    endtask

    typedef struct {
        int          unit;
        logic [4:0]  off;
        logic [2:0]  cnt;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [31:0] held;
        int waitc;

        vecs[0] = '{0, 5'd4,  3'd3, 32'h00345678, 5};
        vecs[1] = '{0, 5'd30, 3'd4, 32'h33AA2211, 6};
        vecs[2] = '{0, 5'd9,  3'd0, 32'h00000000, 1};
        vecs[3] = '{0, 5'd0,  3'd1, 32'h000000AA, 3};
        vecs[4] = '{0, 5'd31, 3'd2, 32'h0000AA22, 4};
        vecs[5] = '{0, 5'd6,  3'd5, 32'h49481234, 6};
        vecs[6] = '{1, 5'd5,  3'd3, 32'h00B1B0B5, 5};
        vecs[7] = '{1, 5'd7,  3'd2, 32'h0000B2B1, 4};
        vecs[8] = '{1, 5'd3,  3'd4, 32'hB0B5B4B3, 6};

        for (int i = 0; i < 32; i++) mem0[i] = 8'h40 + 8'(i);
        mem0[4] = 8'h78; mem0[5] = 8'h56; mem0[6] = 8'h34; mem0[7] = 8'h12;
        mem0[30] = 8'h11; mem0[31] = 8'h22; mem0[0] = 8'hAA; mem0[1] = 8'h33;
        for (int i = 0; i < 6; i++) mem1[i] = 8'hB0 + 8'(i);

        for (int u = 0; u < 2; u++) begin
            req_valid_a[u] = 1'b0; req_offset_a[u] = '0;
            req_count_a[u] = '0;   resp_ready_a[u] = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'b0, rdy0}, 32'd1);
        chk("rst_rd_en", {31'b0, rden0}, 32'd0);
        chk("rst_rd_addr", {27'b0, rdaddr0}, 32'd0);
        chk("rst_resp_valid", {31'b0, rv0}, 32'd0);
        chk("rst_resp_data", rdata0, 32'd0);
        rst_n = 1'b1;

        // Table-driven transactions
        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].unit, vecs[i].off, vecs[i].cnt, vecs[i].exp_data, vecs[i].exp_lat);
        end

        // Over-range count is clamped to four reads
        mem0[0] = 8'h01; mem0[1] = 8'h02; mem0[2] = 8'h03; mem0[3] = 8'h04;
        do_req(0, 5'd0, 3'd7, 32'h04030201, 6);

        // Backpressure with a second request waiting
        @(negedge clk);
        req_valid_a[0] = 1'b1; req_offset_a[0] = 5'd4; req_count_a[0] = 3'd3;
        @(posedge clk);
        #1;
        req_offset_a[0] = 5'd10; req_count_a[0] = 3'd2;   // second request, held
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
            chk("busy_req_ready", {31'b0, rdy0}, 32'd0);
        end while (!rv0 && waitc < 40);
        held = rdata0;
        chk("bp_first_data", held, 32'h00345678);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_resp_valid", {31'b0, rv0}, 32'd1);
            chk("bp_resp_stable", rdata0, 32'h00345678);
            chk("bp_req_ready", {31'b0, rdy0}, 32'd0);
        end
        resp_ready_a[0] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready_a[0] = 1'b0;
        @(negedge clk);
        chk("bp_second_ready", {31'b0, rdy0}, 32'd1);
        @(posedge clk);
        #1;
        req_valid_a[0] = 1'b0;
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (!rv0 && waitc < 40);
        chk("bp_second_lat", waitc, 4);
        chk("bp_second_data", rdata0, 32'h00004B4A);
        resp_ready_a[0] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready_a[0] = 1'b0;
        $display("txn backpressure sequence done");

        // Asynchronous reset during ISSUE aborts the request
        @(negedge clk);
        req_valid_a[0] = 1'b1; req_offset_a[0] = 5'd0; req_count_a[0] = 3'd4;
        @(posedge clk);
        #1;
        req_valid_a[0] = 1'b0;
        @(negedge clk);
        chk("abort_issue_rd_en", {31'b0, rden0}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_rd_en", {31'b0, rden0}, 32'd0);
        chk("abort_resp_valid", {31'b0, rv0}, 32'd0);
        chk("abort_resp_data", rdata0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_req_ready", {31'b0, rdy0}, 32'd1);
        chk("abort_no_resp", {31'b0, rv0}, 32'd0);
        $display("txn reset abort sequence done");
        mem0[0] = 8'hAA;
        do_req(0, 5'd0, 3'd1, 32'h000000AA, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rng_state_reader.md
Name: rng_state_reader

Overview:
Hardware read-side engine for RNG state byte arrays. It accepts a request for 0..MAX_BYTES consecutive bytes starting at a byte offset. It fetches them one per cycle through a synchronous byte-read port on the state store, assembles them little-endian into one word, and returns the word over a valid/ready response channel. It is the read counterpart of the byte-wise state writers: bytes written from an int at offset K read back as the same int at offset K.

Parameters:
NUM_BYTES, 32, size of the state store in bytes (>=2; need not be a power of two)
MAX_BYTES, 4, maximum bytes per request; response width is 8*MAX_BYTES
ADDR_W, $clog2(NUM_BYTES), byte address width (derived; do not override)

Ports:
clk  in  1  single clock; all logic on posedge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  engine can accept a request
req_offset  in  ADDR_W  starting byte offset
req_count  in  $clog2(MAX_BYTES)+1  number of bytes requested
rd_en  out  1  byte read strobe to state store
rd_addr  out  ADDR_W  byte address for the current read
rd_data  in  8  store data; valid the cycle after rd_en
resp_valid  out  1  assembled word available
resp_ready  in  1  consumer accepts word
resp_data  out  8*MAX_BYTES  assembled word; byte k at bits [8k+7:8k]; unread bytes zero

Behaviour:
- Reset (async assert, sync release): state IDLE; req_ready=1; rd_en=0; rd_addr=0; resp_valid=0; resp_data=0; all counters cleared. Assertion mid-operation aborts the request; no partial response is ever emitted.
- FSM states: IDLE, ISSUE, DRAIN, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready at edge T:
  - latch N=min(req_count,MAX_BYTES);
  - latch base=req_offset mod NUM_BYTES;
  - clear the word accumulator;
  - go to ISSUE if N>0, else RESP.
- ISSUE: for cycles T+1..T+N, drive rd_en=1 and rd_addr=(base+k) mod NUM_BYTES for k=0..N-1. Wrap is explicit compare-and-subtract, correct for non-power-of-two NUM_BYTES. After the last issue, go to DRAIN.
- Capture: at edge T+2+k, rd_data is written into byte lane k. Issue and capture overlap, so throughput is 1 byte/cycle.
- DRAIN: one cycle (T+N+1) with rd_en=0, in which the final byte is captured; then go to RESP.
- RESP: resp_valid=1 from cycle T+N+2 (T+1 when N=0).
  - resp_data and resp_valid are held stable until resp_valid&&resp_ready.
  - On that handshake edge, return to IDLE; req_ready=1 the next cycle. No request/response overlap.
- req_ready=0 in every state except IDLE. Requests presented while busy are not accepted; the producer must hold them.
- Count rules:
  - N=0 returns resp_data=0 and issues no reads.
  - req_count>MAX_BYTES is clamped to MAX_BYTES.
  - Bytes above lane N-1 are zero.
- Latency, acceptance to resp_valid: N+2 cycles, or 1 cycle for N=0.
- rd_en is never asserted outside ISSUE. The store must not see extra reads.
- req_offset/req_count changes after acceptance have no effect.

Test Plan:
- Store bytes [4]=0x78,[5]=0x56,[6]=0x34,[7]=0x12; request offset 4, count 3 -> rd_addr 4,5,6 on consecutive cycles; resp_valid 5 cycles after acceptance; resp_data=0x00345678.
- NUM_BYTES=32, bytes [30]=0x11,[31]=0x22,[0]=0xAA,[1]=0x33; offset 30, count 4 -> rd_addr 30,31,0,1; resp_data=0x33AA2211.
- Count 0 at offset 9 -> no rd_en pulses; resp_valid 1 cycle after acceptance; resp_data=0. Count 7 at offset 0 with bytes 0..3=0x01..0x04 -> exactly 4 reads; resp_data=0x04030201.
- resp_ready held low 10 cycles with a second req_valid asserted -> resp_data stable, req_ready=0 throughout. The second request is accepted only the cycle after the response handshake.
- Assert rst_n low during ISSUE of a count-4 request -> rd_en, resp_valid and resp_data are 0 immediately (asynchronously). After release: req_ready=1, and a new request at offset 0, count 1 with byte [0]=0xAA returns 0x000000AA.
- NUM_BYTES=6 build: offset 5, count 3 -> rd_addr 5,0,1 (non-power-of-two wrap).
